jkreg_bank_p: RTL and testbench

Parametrised N-bit multi-mode JK register for the datapath. It replaces single-function JK flip-flop columns with one block that supports hold, per-bit JK update, parallel load, and binary up-count, plus a full-width scan chain and a terminal-count flag. It sits in the datapath groups wherever a JK register, loadable register or small counter was previously instantiated separately.

---
 rtl/jkreg_bank_p.sv | 128 ++++++++++++
 tb/tb_jkreg_bank_p.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jkreg_bank_p.sv
// -----------------------------------------------------------------------------
// jkreg_bank_p
//
// Purpose:
//   N-bit multi-mode JK register bank. It can hold, update each bit as a JK
//   flip-flop, load in parallel, or count up in binary. A full-width scan
//   chain shifts from SCANIN into Q[0] and out of Q[N-1]. TC flags the cycle
//   before an up-count wraps from all ones to zero.
//
// Optional feature (compile-time macro JKREG_SHADOW_EN):
//   When the macro is defined, the CAPTURE input and the SHADOW output are
//   added. SHADOW holds a copy of Q as it was before the capturing edge.
//   When the macro is not defined, neither port nor any shadow flop exists.
//
// Parameters:
//   N       register width in bits (1..128)
//   RSTVAL  value forced onto Q while RST is high
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous reset, active-high
//   EN       in   functional update enable (scan is not affected)
//   MODE     in   00 hold, 01 JK, 10 load, 11 count
//   J, K     in   per-bit JK controls (MODE 01)
//   D        in   parallel load data (MODE 10)
//   TEST     in   scan mode, overrides EN/MODE
//   SCANIN   in   serial scan input into Q[0]
//   Q        out  register state
//   SCANOUT  out  Q[N-1]
//   TC       out  terminal count (count mode, enabled, Q all ones)
//   CAPTURE  in   shadow capture strobe (JKREG_SHADOW_EN only)
//   SHADOW   out  shadow copy of Q (JKREG_SHADOW_EN only)
// -----------------------------------------------------------------------------
module jkreg_bank_p #(
  parameter int            N      = 8,
  parameter logic [N-1:0]  RSTVAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [1:0]   MODE,
  input  logic [N-1:0] J,
  input  logic [N-1:0] K,
  input  logic [N-1:0] D,
  input  logic         TEST,
  input  logic         SCANIN,
  output logic [N-1:0] Q,
  output logic         SCANOUT,
  output logic         TC
`ifdef JKREG_SHADOW_EN
  ,
  input  logic         CAPTURE,
  output logic [N-1:0] SHADOW
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_JK    = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  mode_t        mode_sel;
  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;
  logic [N-1:0] q_shift;

  assign mode_sel = mode_t'(MODE);

  // The scan shift is built in a generate branch so that a 1-bit register
  // never elaborates the empty slice q_reg[N-2:0].
  generate
    if (N == 1) begin : g_shift_one
      assign q_shift = SCANIN;
    end else begin : g_shift_wide
      assign q_shift = {q_reg[N-2:0], SCANIN};
    end
  endgenerate

  // Next-state selection in priority order: scan, enable, then mode.
  // The JK expression gives hold/set/clear/toggle per bit:
  // a bit is 1 next if it is 1 and not cleared, or it is 0 and set.
  always_comb begin
    q_next = q_reg;
    if (TEST) begin
      q_next = q_shift;
    end else if (EN) begin
      unique case (mode_sel)
        MODE_HOLD:  q_next = q_reg;
        MODE_JK:    q_next = (q_reg & ~K) | (~q_reg & J);
        MODE_LOAD:  q_next = D;
        MODE_COUNT: q_next = q_reg + N'(1);
        default:    q_next = q_reg;
      endcase
    end
  end

  // State register; reset overrides everything, including the clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_reg <= RSTVAL;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q       = q_reg;
  assign SCANOUT = q_reg[N-1];

  // TC is only meaningful while the register is actually counting, so it
  // is gated by the same controls that select the count path.
  assign TC = (mode_sel == MODE_COUNT) & EN & ~TEST & (&q_reg);

`ifdef JKREG_SHADOW_EN
  // Shadow copy samples Q before this edge's update, so a capture taken
  // while counting records the value that was about to be replaced.
  // Scan mode does not block the capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SHADOW <= '0;
    end else if (CAPTURE) begin
      SHADOW <= q_reg;
    end
  end
`endif

endmodule

// File: tb/tb_jkreg_bank_p.sv
// -----------------------------------------------------------------------------
// tb_jkreg_bank_p
//
// Directed test of jkreg_bank_p with N=8 and RSTVAL=8'hA5. It covers reset,
// JK update, load, count and terminal count, enable hold, scan shifting,
// reset during a count and, when JKREG_SHADOW_EN is defined, shadow capture.
// -----------------------------------------------------------------------------
module tb_jkreg_bank_p;

  localparam int          N      = 8;
  localparam logic [7:0]  RSTVAL = 8'hA5;

  logic         CLK;
  logic         RST;
  logic         EN;
  logic [1:0]   MODE;
  logic [N-1:0] J;
  logic [N-1:0] K;
  logic [N-1:0] D;
  logic         TEST;
  logic         SCANIN;
  logic [N-1:0] Q;
  logic         SCANOUT;
  logic         TC;
`ifdef JKREG_SHADOW_EN
  logic         CAPTURE;
  logic [N-1:0] SHADOW;
`endif

  int checks;
  int errors;

  jkreg_bank_p #(
    .N      (N),
    .RSTVAL (RSTVAL)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .MODE    (MODE),
    .J       (J),
    .K       (K),
    .D       (D),
    .TEST    (TEST),
    .SCANIN  (SCANIN),
    .Q       (Q),
    .SCANOUT (SCANOUT),
    .TC      (TC)
`ifdef JKREG_SHADOW_EN
    ,
    .CAPTURE (CAPTURE),
    .SHADOW  (SHADOW)
`endif
  );

  // Clock with rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One comparison: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Set the functional controls for the next edge.
  task automatic applyStimulus(input logic en, input logic [1:0] mode,
                               input logic [7:0] j, input logic [7:0] k,
                               input logic [7:0] d);
    EN   = en;
    MODE = mode;
    J    = j;
    K    = k;
    D    = d;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] expScan;
  logic [7:0] scanBits;

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b0;
    TEST     = 1'b0;
    SCANIN   = 1'b0;
`ifdef JKREG_SHADOW_EN
    CAPTURE  = 1'b0;
`endif
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h00);

    // Reset applied between edges takes effect at once.
    #2 RST = 1'b1;
    #1;
    checkOutput("reset_async_q", Q, 8'hA5);
    checkOutput("reset_scanout", SCANOUT, 1'b1);
    checkOutput("reset_tc", TC, 1'b0);
    repeat (3) tick();
    checkOutput("reset_hold_3_edges", Q, 8'hA5);
    #2 RST = 1'b0;

    // Load F0, then a JK update covering hold/set/clear/toggle.
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 8'hF0);
    tick();
    checkOutput("load_f0", Q, 8'hF0);
    applyStimulus(1'b1, 2'b01, 8'h8D, 8'hB1, 8'h00);
    tick();
    checkOutput("jk_update", Q, 8'h4D);

    // EN low and MODE 00 both hold.
    applyStimulus(1'b0, 2'b10, 8'hFF, 8'hFF, 8'h00);
    tick();
    checkOutput("en_low_hold", Q, 8'h4D);
    applyStimulus(1'b1, 2'b00, 8'hFF, 8'h00, 8'h00);
    tick();
    checkOutput("mode_hold", Q, 8'h4D);

    // Load FE, then count through the wrap.
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 8'hFE);
    tick();
    checkOutput("load_fe", Q, 8'hFE);
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h00);
    #1;
    checkOutput("tc_at_fe", TC, 1'b0);
    tick();
    checkOutput("count_ff", Q, 8'hFF);
    checkOutput("tc_at_ff", TC, 1'b1);
    EN = 1'b0;
    #1;
    checkOutput("tc_en_low", TC, 1'b0);
    tick();
    checkOutput("count_en_low_hold", Q, 8'hFF);
    EN = 1'b1;
    #1;
    checkOutput("tc_ff_again", TC, 1'b1);
    MODE = 2'b10;
    #1;
    checkOutput("tc_load_mode", TC, 1'b0);
    MODE = 2'b11;
    tick();
    checkOutput("count_wrap_00", Q, 8'h00);
    checkOutput("tc_after_wrap", TC, 1'b0);
    tick();
    checkOutput("count_01", Q, 8'h01);

    // Clear, then shift 1,0,1,1,0,0,1,0 with TEST overriding a load of FF.
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("clear_before_scan", Q, 8'h00);
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 8'hFF);
    TEST     = 1'b1;
    expScan  = 8'h00;
    scanBits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      SCANIN  = scanBits[i];
      expScan = {expScan[6:0], scanBits[i]};
      tick();
      checkOutput($sformatf("scan_q_%0d", 7 - i), Q, expScan);
      checkOutput($sformatf("scan_out_%0d", 7 - i), SCANOUT, expScan[7]);
    end
    checkOutput("scan_final_b2", Q, 8'hB2);
    MODE = 2'b11;
    D    = 8'h00;
    #1;
    checkOutput("tc_in_test", TC, 1'b0);
    TEST   = 1'b0;
    SCANIN = 1'b0;

    // Reset in the middle of a count, then resume from RSTVAL.
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 8'h36);
    tick();
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("count_37", Q, 8'h37);
    #2 RST = 1'b1;
    #1;
    checkOutput("reset_mid_count", Q, 8'hA5);
    #1 RST = 1'b0;
    tick();
    checkOutput("resume_after_reset", Q, 8'hA6);

`ifdef JKREG_SHADOW_EN
    // Shadow takes the pre-edge value and holds without CAPTURE.
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 8'h10);
    tick();
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h00);
    CAPTURE = 1'b1;
    tick();
    checkOutput("shadow_capture", SHADOW, 8'h10);
    checkOutput("shadow_q_11", Q, 8'h11);
    CAPTURE = 1'b0;
    tick();
    checkOutput("shadow_hold", SHADOW, 8'h10);
    checkOutput("shadow_q_12", Q, 8'h12);
    #2 RST = 1'b1;
    #1;
    checkOutput("shadow_reset", SHADOW, 8'h00);
    #1 RST = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
